// File: rtl/lpfn_pkg.sv
// Shared constants and helpers for the lpfn low-pass filter slice.
// Default data widths, the smoothing-shift width and the lock counter
// width calculation live here so the top and the lock detector agree.
package lpfn_pkg;

  localparam int IN_W_DEF     = 3;
  localparam int FRAC_W_DEF   = 11;
  localparam int OUT_FRAC_DEF = 5;
  localparam int K_W          = 4;

  // Bits needed to count from 0 up to lock_cnt inclusive (at least 1).
  function automatic int lock_cnt_width(input int lock_cnt);
    int w;
    w = $clog2(lock_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lpfn_lock_det.sv
// Settle/lock detector for the lpfn filter.
// Counts consecutive updates whose pre-update error magnitude, expressed in
// output LSBs, stays within LOCK_TH. The counter saturates at LOCK_CNT and
// locked is the registered "counter full" flag. A clear (load) or a
// non-qualifying update restarts the count; idle cycles hold it.
module lpfn_lock_det
  import lpfn_pkg::*;
#(
  parameter int ERR_W    = 15,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int OUT_FRAC = OUT_FRAC_DEF,
  parameter int LOCK_TH  = 1,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    upd,
  input  logic                    clr,
  output logic                    locked
);

  localparam int CW = lock_cnt_width(LOCK_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

  logic [ERR_W-1:0] err_mag;
  logic [ERR_W-1:0] err_lsb;
  logic             in_th;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             locked_reg;

  // The most negative error still fits as an unsigned magnitude in ERR_W bits.
  assign err_mag = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
  assign err_lsb = err_mag >> (FRAC_W - OUT_FRAC);
  assign in_th   = (err_lsb <= ERR_W'(LOCK_TH));

  // Next count: clear wins, qualifying updates count up to saturation.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (upd) begin
      if (!in_th)
        cnt_next = '0;
      else if (cnt_reg != CNT_MAX)
        cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter and registered lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      locked_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      locked_reg <= (cnt_next == CNT_MAX);
    end
  end

  assign locked = locked_reg;

endmodule

// File: rtl/lpfn_param.sv
// First-order IIR low-pass filter (exponential moving average), alpha = 2^-k.
// The accumulator holds IN_W integer and FRAC_W fractional bits; avgn is the
// truncated top slice of it. load presets the accumulator and beats a
// simultaneous sample. Optional lock detector: define LPFN_LOCK_DET_EN,
// otherwise locked is tied low.
module lpfn_param
  import lpfn_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int OUT_FRAC = OUT_FRAC_DEF,
  parameter int INIT     = 3,
  parameter int LOCK_TH  = 1,
  parameter int LOCK_CNT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          n,
  input  logic [K_W-1:0]           k,
  input  logic                     load,
  input  logic [IN_W-1:0]          load_val,
  output logic [IN_W+OUT_FRAC-1:0] avgn,
  output logic                     out_valid,
  output logic                     locked
);

  localparam int ACC_W = IN_W + FRAC_W;
  localparam int ERR_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(INIT) << FRAC_W;

  // Reject configurations the datapath slicing cannot represent.
  if (OUT_FRAC < 1 || OUT_FRAC > FRAC_W || LOCK_CNT < 1 || LOCK_TH < 0) begin : g_bad_cfg
    $error("lpfn_param: invalid OUT_FRAC / LOCK_CNT / LOCK_TH configuration");
  end

  logic [ACC_W-1:0]        acc_reg;
  logic [ACC_W-1:0]        acc_next;
  logic [ACC_W-1:0]        acc_upd;
  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] err_sh;
  logic                    out_valid_reg;

  // One extra sign bit keeps the difference exact in both directions.
  assign err    = $signed({1'b0, n, {FRAC_W{1'b0}}}) - $signed({1'b0, acc_reg});
  assign err_sh = err >>> k;
  // The step never leaves [acc, n<<FRAC_W], so dropping the sign bit is safe.
  assign acc_upd = ACC_W'($signed({1'b0, acc_reg}) + err_sh);

  // Accumulator next state: load beats a sample, idle holds.
  always_comb begin
    acc_next = acc_reg;
    if (load)
      acc_next = {load_val, {FRAC_W{1'b0}}};
    else if (in_valid)
      acc_next = acc_upd;
  end

  // Accumulator and output strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= ACC_RST;
      out_valid_reg <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      out_valid_reg <= in_valid | load;
    end
  end

  assign avgn      = acc_reg[ACC_W-1:FRAC_W-OUT_FRAC];
  assign out_valid = out_valid_reg;

`ifdef LPFN_LOCK_DET_EN
  lpfn_lock_det #(
    .ERR_W    (ERR_W),
    .FRAC_W   (FRAC_W),
    .OUT_FRAC (OUT_FRAC),
    .LOCK_TH  (LOCK_TH),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk    (clk),
    .rst    (rst),
    .err    (err),
    .upd    (in_valid & ~load),
    .clr    (load),
    .locked (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule
